// File: rtl/input_port_router.sv
// NoC input stage: FIFO-buffers flits, XY-routes the head flit, and holds the route until the tail leaves.
// A head pushed at edge t requests from t+2; pops only on grant; in_ready drops while the FIFO is full (no bypass).
module input_port_router #(
  parameter int DEPTH = 4,
  parameter int X_ID  = 1,
  parameter int Y_ID  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_gate,
  input  logic        out_grant,
  output logic        err_drop
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  typedef logic [AW:0] cnt_t;
  localparam cnt_t       FULL_CNT  = cnt_t'(DEPTH);
  localparam logic [2:0] GATE_NONE = 3'd5;
  localparam logic [1:0] X_L       = 2'(X_ID);
  localparam logic [1:0] Y_L       = 2'(Y_ID);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t          count_q, count_d;
  state_t        state_q, state_d;
  logic [2:0]    route_q, route_d;

  logic        empty, push, pop, drop;
  logic [31:0] head;

  function automatic logic [2:0] xy_route(input logic [3:0] dst);
    logic [1:0] dx, dy;
    dx = dst[3:2];
    dy = dst[1:0];
    if (dx > X_L)      xy_route = 3'd1;
    else if (dx < X_L) xy_route = 3'd3;
    else if (dy > Y_L) xy_route = 3'd0;
    else if (dy < Y_L) xy_route = 3'd2;
    else               xy_route = 3'd4;
  endfunction

  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;

  // Next-state: head bit [31] marks head/single, bit [30] marks the last flit of a packet.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    pop     = 1'b0;
    drop    = 1'b0;
    if (enable && !empty) begin
      case (state_q)
        IDLE: begin
          if (head[31]) begin
            route_d = xy_route(head[29:26]);
            state_d = ACTIVE;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
        ACTIVE: begin
          if (out_grant) begin
            pop = 1'b1;
            if (head[30]) begin
              state_d = IDLE;
              route_d = GATE_NONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
  end

  // Outputs: a locked port with an empty FIFO shows a bubble but keeps its route.
  always_comb begin
    out_gate = GATE_NONE;
    if (enable && state_q == ACTIVE && !empty) out_gate = route_q;
    out_data = empty ? 32'd0 : head;
    err_drop = drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      route_q  <= GATE_NONE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_input_port_router.sv
// Scoreboarded bench: accepted flits are classified by a packet-level model; a negedge monitor checks every pop and drop.
module tb_input_port_router;
  localparam int X = 1, Y = 1;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, out_grant = 1'b0;
  logic        in_ready, err_drop;
  logic [31:0] out_data;
  logic [2:0]  out_gate;

  input_port_router #(.DEPTH(4), .X_ID(X), .Y_ID(Y)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_gate(out_gate),
    .out_grant(out_grant), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [2:0]  gate;
    bit          drop;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  bit         m_locked = 0;
  logic [2:0] m_gate = 3'd5;
  int         n_cmp = 0, n_err = 0, drop_cnt = 0, fwd_cnt = 0;
  bit         mon_on = 0, rnd_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [2:0] ref_route(input logic [31:0] d);
    int dx, dy;
    dx = int'(d[29:28]);
    dy = int'(d[27:26]);
    if (dx > X) return 3'd1;
    if (dx < X) return 3'd3;
    if (dy > Y) return 3'd0;
    if (dy < Y) return 3'd2;
    return 3'd4;
  endfunction

  // Packet-level model: the fate of each flit depends only on arrival order.
  function automatic void model_accept(input logic [31:0] d);
    exp_t e;
    e.dat = d;
    if (!m_locked) begin
      if (d[31:30] == 2'b10 || d[31:30] == 2'b11) begin
        m_gate   = ref_route(d);
        m_locked = (d[31:30] == 2'b10);
        e.gate = m_gate;
        e.drop = 0;
      end else begin
        e.gate = 3'd5;
        e.drop = 1;
      end
    end else begin
      e.gate = m_gate;
      e.drop = 0;
      if (d[31:30] == 2'b01 || d[31:30] == 2'b11) m_locked = 0;
    end
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic rdy;
      rdy = in_ready;
      step();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) model_accept(d);
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: flit %h not accepted within 300 cycles", d);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && rst) begin
      if (!enable) begin
        chk("gate_while_disabled", 32'(out_gate), 32'd5);
        chk("drop_while_disabled", 32'(err_drop), 32'd0);
      end else begin
        if (err_drop) begin
          drop_cnt++;
          if (exp_q.size() == 0) chk("unexpected_drop_queue_size", 32'd0, 32'd1);
          else begin
            mon_e = exp_q.pop_front();
            chk("drop_expected", 32'(mon_e.drop), 32'd1);
            chk("drop_data", out_data, mon_e.dat);
          end
        end
        if (out_gate != 3'd5 && out_grant) begin
          fwd_cnt++;
          if (exp_q.size() == 0) chk("unexpected_pop_queue_size", 32'd0, 32'd1);
          else begin
            mon_e = exp_q.pop_front();
            chk("fwd_not_drop", 32'(mon_e.drop), 32'd0);
            chk("fwd_data", out_data, mon_e.dat);
            chk("fwd_gate", 32'(out_gate), 32'(mon_e.gate));
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_mode) begin
      out_grant = ($urandom_range(0, 1) == 1);
      enable    = ($urandom_range(0, 4) != 0);
    end
  end

  initial begin
    int d0, f0;
    logic [31:0] fl;
    repeat (3) step();
    rst = 1'b1;
    mon_on = 1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_gate", 32'(out_gate), 32'd5);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_err_drop", 32'(err_drop), 32'd0);
    step();

    // Single flit to (0,0): two-cycle route latency, then west.
    send(32'hC000_0000);
    @(negedge clk); chk("t1_gate_idle_cycle", 32'(out_gate), 32'd5);
    step();
    @(negedge clk); chk("t1_gate_route", 32'(out_gate), 32'd3);
    step();
    out_grant = 1'b1; step(); out_grant = 1'b0;
    @(negedge clk); chk("t1_gate_after_pop", 32'(out_gate), 32'd5);
    chk("t1_data_after_pop", out_data, 32'd0);
    step();

    // Three-flit packet to own node under continuous grant.
    f0 = fwd_cnt;
    out_grant = 1'b1;
    send(32'h9400_0000); send(32'h0000_00AA); send(32'h4000_00BB);
    repeat (5) step();
    out_grant = 1'b0;
    chk("t2_fwd_count", 32'(fwd_cnt - f0), 32'd3);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk); chk("t2_gate_end", 32'(out_gate), 32'd5);
    step();

    // Grant stalled mid-packet: body held, route kept.
    send(32'h9400_0000); send(32'h0000_00AA); send(32'h4000_00BB);
    repeat (2) step();
    out_grant = 1'b1; step(); out_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_gate_hold", 32'(out_gate), 32'd4);
      chk("t3_data_hold", out_data, 32'h0000_00AA);
      step();
    end
    out_grant = 1'b1; repeat (4) step(); out_grant = 1'b0;
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fill to DEPTH, fifth flit held upstream until one grant.
    send(32'hA400_0001); send(32'h0000_0002); send(32'h0000_0003); send(32'h0000_0004);
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'h4000_0005; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_held_in_ready", 32'(in_ready), 32'd0);
    end
    out_grant = 1'b1; step(); out_grant = 1'b0;
    chk("t4_in_ready_after_grant", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    model_accept(32'h4000_0005);
    out_grant = 1'b1; repeat (8) step(); out_grant = 1'b0;
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Orphan body from IDLE is dropped once.
    d0 = drop_cnt;
    send(32'h0000_0011);
    @(negedge clk); chk("t5_gate_on_drop", 32'(out_gate), 32'd5);
    repeat (3) step();
    chk("t5_drop_pulses", 32'(drop_cnt - d0), 32'd1);

    // Reset mid-packet; the late tail becomes an orphan.
    send(32'h9400_0000); send(32'h0000_0022);
    repeat (2) step();
    rst = 1'b0;
    exp_q.delete();
    m_locked = 0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_gate", 32'(out_gate), 32'd5);
    chk("t6_data", out_data, 32'd0);
    step();
    d0 = drop_cnt;
    send(32'h4000_00BB);
    repeat (3) step();
    chk("t6_tail_dropped", 32'(drop_cnt - d0), 32'd1);

    // Randomised packets, orphans, grant and enable.
    rnd_mode = 1;
    for (int p = 0; p < 120; p++) begin
      int len;
      fl = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        fl[31] = 1'b0;
        send(fl);
      end else begin
        len = $urandom_range(1, 4);
        fl[31:30] = (len == 1) ? 2'b11 : 2'b10;
        send(fl);
        for (int k = 1; k < len; k++) begin
          fl = $urandom;
          fl[31:30] = (k == len - 1) ? 2'b01 : 2'b00;
          send(fl);
        end
      end
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_mode = 0;
    @(posedge clk);
    #2;
    enable = 1'b1;
    out_grant = 1'b1;
    repeat (20) step();
    out_grant = 1'b0;
    chk("random_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/input_port_router.md
Name: input_port_router

Overview:
- Per-direction input stage of a NoC3x3 router node, placed directly upstream of the crossbar; one instance per input (PE, north, east, south, west).
- Buffers incoming 32-bit flits in a small FIFO and computes the XY route from the head flit.
- Presents the crossbar with the current flit (`out_data`) and a 3-bit destination gate (`out_gate`).
- Holds the route for the whole packet (wormhole lock) and pops a flit only when the output arbiter grants it.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- X_ID, 1, this node's column in the 3x3 mesh (0..2).
- Y_ID, 1, this node's row in the 3x3 mesh (0..2).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  router enable; same signal as crossbar `enable`.
- in_data  input  32  flit from the upstream link or PE.
- in_valid  input  1  `in_data` is valid this cycle.
- in_ready  output  1  FIFO can accept a flit this cycle.
- out_data  output  32  flit at FIFO head; drives the crossbar `*_data`.
- out_gate  output  3  requested output: 0=N, 1=E, 2=S, 3=W, 4=PE, 5=no request.
- out_grant  input  1  the arbiter for `out_gate` selected this port this cycle.
- err_drop  output  1  one-cycle pulse when an orphan body/tail flit is discarded.

Behaviour:
- Flit type is `[31:30]`: 10=head, 00=body, 01=tail, 11=single (head+tail).
- Head and single flits carry `dest_x` in `[29:28]` and `dest_y` in `[27:26]`.
- Reset (rst=0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, state=IDLE, route_reg=5, err_drop=0.
  - Outputs: `out_gate`=5, `out_data`=32'd0 (memory is not cleared; `out_data` is forced to 0 while empty), `in_ready`=1.
  - Reset mid-packet discards all buffered flits and any lock. Upstream flits still in flight then arrive as orphans and are dropped.
- FIFO:
  - `in_ready` = (count != DEPTH), derived from registered count.
  - Push on posedge when `in_valid` && `in_ready`; pushes occur regardless of `enable`.
  - A full FIFO never pushes, even if a pop happens in the same cycle (no bypass).
  - Push and pop together leave count unchanged. Pointers wrap modulo DEPTH.
  - A pushed flit becomes visible at the FIFO head on the next cycle.
- Route function (head or single flit at FIFO head):
  - dest_x > X_ID → 1 (E); dest_x < X_ID → 3 (W).
  - Otherwise dest_y > Y_ID → 0 (N); dest_y < Y_ID → 2 (S); otherwise → 4 (PE).
  - No mesh-boundary checking is done.
- FSM when `enable`=1. When `enable`=0 the FSM, pops and `err_drop` are frozen (err_drop=0); `out_gate` is forced to 5.
  - IDLE, FIFO empty: `out_gate`=5; stay in IDLE.
  - IDLE, head/single at FIFO head: latch route into route_reg; go to ACTIVE. Nothing is popped this cycle. `out_gate`=5 in IDLE.
  - IDLE, body/tail at FIFO head: pop it, pulse `err_drop`=1, stay in IDLE.
  - ACTIVE: `out_gate` = route_reg if FIFO is non-empty, else 5 (bubble; the lock is held).
  - ACTIVE pop: only when `out_grant`=1 and `out_gate`!=5; `out_grant` is ignored otherwise.
  - ACTIVE, popped flit is tail or single: go to IDLE, route_reg=5.
  - ACTIVE, a second head flit arriving inside a locked packet is forwarded as a normal flit (no check).
- Latency: head pushed at edge t reaches the FIFO head in cycle t+1 (route latched in IDLE). `out_gate` is valid from cycle t+2. Minimum head-to-head spacing is two cycles per packet, due to the IDLE route cycle.
- Throughput: one flit per cycle in ACTIVE under continuous grant.

Test Plan:
1. X_ID=1, Y_ID=1; push single flit 32'hC000_0000 (dest 0,0) → two cycles later `out_gate`=3; grant for one cycle → FIFO empty, state IDLE, `out_gate`=5.
2. Push head 32'h9400_0000 (dest 1,1), body 32'h0000_00AA, tail 32'h4000_00BB with grant held high → `out_gate`=4 for three consecutive cycles; `out_data` = head, AA, BB in order; then `out_gate`=5.
3. Same 3-flit packet with `out_grant` low for 5 cycles mid-packet → `out_gate` stays 4; `out_data` holds the body flit; no flit lost or duplicated.
4. DEPTH=4, grant low, push 5 flits back-to-back → `in_ready`=0 after the 4th push; 5th is held upstream; one grant → `in_ready`=1 on the next cycle.
5. From IDLE, push body 32'h0000_0011 → `err_drop` pulses once; flit popped; `out_gate` stays 5.
6. Reset asserted after head+body with tail pending → after reset count=0, `out_gate`=5, `in_ready`=1. A subsequently pushed tail causes an `err_drop` pulse.
